// File: rtl/mac_pkg.sv
// Shared types for the MAC stage, its result FIFO and its property module.
package mac_pkg;

  localparam int MAC_DATA_W = 32;

  typedef logic [MAC_DATA_W-1:0] mac_word_t;

endpackage

// File: rtl/mac_fifo_ram.sv
// Storage array for the MAC result FIFO: one synchronous write port, one
// asynchronous read port, deliberately without reset.
module mac_fifo_ram
  import mac_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = MAC_DATA_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/mac_result_fifo.sv
// First-word-fall-through buffer for MAC results with sticky overflow detection.
// Define MAC_FIFO_DROPCNT_EN to add a saturating 16-bit dropped-result counter.
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = MAC_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef MAC_FIFO_DROPCNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  mac_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (w_push),
    .i_wrAddr (r_wrPtr),
    .i_wrData (in_data),
    .i_rdAddr (r_rdPtr),
    .o_rdData (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + ADDR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + ADDR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

`ifdef MAC_FIFO_DROPCNT_EN
  logic [15:0] r_dropCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropCnt != 16'hFFFF) r_dropCnt <= r_dropCnt + 16'd1;
    end
  end

  assign drop_cnt = r_dropCnt;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end
`endif

  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo: vector table plus scoreboard-checked
// corner sequences. Honours MAC_FIFO_DROPCNT_EN when defined.
module tb_mac_result_fifo;
  import mac_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  mac_word_t        inData;
  logic             outValid;
  logic             outReady;
  mac_word_t        outData;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
`ifdef MAC_FIFO_DROPCNT_EN
  logic [15:0]      dropCnt;
`endif

  int        checks   = 0;
  int        failures = 0;
  mac_word_t sbQueue[$];
  logic      modelOverflow;
  int        modelDrops;

  typedef struct {
    logic      iv;
    mac_word_t data;
    logic      rdy;
    int        expCount;
    logic      expEmpty;
  } vec_t;

  vec_t vecs[6];

  mac_result_fifo #(.DEPTH(DEPTH), .DATA_W(MAC_DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_data   (inData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
`ifdef MAC_FIFO_DROPCNT_EN
    ,
    .drop_cnt  (dropCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare every status output against the reference queue model.
  task automatic checkStatus(input string tag);
    int n;
    n = sbQueue.size();
    checkOutput({tag, " count"}, 32'(count), 32'(n));
    checkOutput({tag, " empty"}, 32'(empty), 32'(n == 0));
    checkOutput({tag, " full"}, 32'(full), 32'(n == DEPTH));
    checkOutput({tag, " out_valid"}, 32'(outValid), 32'(n != 0));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(modelOverflow));
`ifdef MAC_FIFO_DROPCNT_EN
    checkOutput({tag, " drop_cnt"}, 32'(dropCnt), 32'(modelDrops));
`endif
  endtask

  // Called just after a falling edge: drives one cycle of inputs, checks the
  // popped head against the scoreboard, advances the model, then checks status.
  task automatic applyStimulus(input logic iv, input mac_word_t d, input logic rdy,
                               input string tag);
    logic wasFull;
    logic pop;
    inValid = iv;
    inData  = d;
    outReady = rdy;
    wasFull = (sbQueue.size() == DEPTH);
    pop = (sbQueue.size() != 0) && rdy;
    if (pop) begin
      checkOutput({tag, " out_data"}, outData, sbQueue[0]);
      void'(sbQueue.pop_front());
    end
    if (iv && (!wasFull || pop)) sbQueue.push_back(d);
    else if (iv) begin
      modelOverflow = 1'b1;
      if (modelDrops < 65535) modelDrops++;
    end
    @(posedge clk);
    @(negedge clk);
    checkStatus(tag);
  endtask

  task automatic drainAll(input string tag);
    int n;
    n = sbQueue.size();
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, tag);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'd5, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b1, 32'd7, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b1, 32'd9, 1'b0, 3, 1'b0};
    vecs[3] = '{1'b0, 32'd0, 1'b1, 2, 1'b0};
    vecs[4] = '{1'b0, 32'd0, 1'b1, 1, 1'b0};
    vecs[5] = '{1'b0, 32'd0, 1'b1, 0, 1'b1};

    modelOverflow = 1'b0;
    modelDrops    = 0;
    rst      = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;

    // Reset must take effect before any clock edge, even with in_valid high.
    #1;
    rst     = 1'b1;
    inValid = 1'b1;
    inData  = 32'hDEAD;
    #1;
    checkStatus("reset async");
    @(negedge clk);
    checkStatus("reset held");
    inValid = 1'b0;
    rst     = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].data, vecs[i].rdy, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d table count", i), 32'(count), 32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d table empty", i), 32'(empty), 32'(vecs[i].expEmpty));
    end

    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 32'(i), 1'b0, "fill");
    applyStimulus(1'b1, 32'd99, 1'b0, "drop");
    checkOutput("drop overflow", 32'(overflow), 32'd1);
    checkOutput("drop count", 32'(count), 32'd8);
`ifdef MAC_FIFO_DROPCNT_EN
    checkOutput("drop drop_cnt", 32'(dropCnt), 32'd1);
`endif
    drainAll("drain1");

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(101 + i), 1'b0, "refill");
    applyStimulus(1'b1, 32'd42, 1'b1, "full push+pop");
    checkOutput("full push+pop count", 32'(count), 32'd8);
    checkOutput("full push+pop overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b1, "drain2");
    checkOutput("last head is 42", outData, 32'd42);
    applyStimulus(1'b0, '0, 1'b1, "drain2 last");

    applyStimulus(1'b0, '0, 1'b1, "ready on empty");
    checkOutput("ready on empty valid", 32'(outValid), 32'd0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(500 + i), 1'b1, "stream");
      checkOutput("stream count<=1", 32'(count > 1), 32'd0);
    end
    drainAll("stream tail");

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(10 + i), 1'b0, "pre-reset");
    rst = 1'b1;
    #1;
    sbQueue.delete();
    modelOverflow = 1'b0;
    modelDrops    = 0;
    checkOutput("mid reset count", 32'(count), 32'd0);
    checkOutput("mid reset out_valid", 32'(outValid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'd3, 1'b0, "post-reset push");
    checkOutput("post-reset out_data", outData, 32'd3);
    checkOutput("post-reset out_valid", 32'(outValid), 32'd1);
    drainAll("post-reset drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
